// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard controller: tracks in-flight writers through EX/MEM/WB and stalls dependent decodes.
// Optional feature macro FWD_EN: enables EX/MEM forwarding select outputs with load-use stalling only.
module hazard_scoreboard (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [2:0]  id_rs1,
  input  logic [2:0]  id_rs2,
  input  logic        id_rs1_use,
  input  logic        id_rs2_use,
  input  logic [2:0]  id_rd,
  input  logic        id_rd_we,
  input  logic        id_is_load,
  input  logic        flush,
  output logic        stall,
  output logic        ex_we,
  output logic        mem_we,
  output logic        wb_we,
  output logic [2:0]  ex_rd,
  output logic [2:0]  mem_rd,
  output logic [2:0]  wb_rd,
  output logic [1:0]  fwd1_sel,
  output logic [1:0]  fwd2_sel,
  output logic [15:0] stall_cnt
);

  logic        r_ex_we, r_mem_we, r_wb_we;
  logic [2:0]  r_ex_rd, r_mem_rd, r_wb_rd;
  logic        r_ex_ld, r_mem_ld, r_wb_ld;
  logic [15:0] r_stall_cnt;

  logic w_ex_m1, w_ex_m2, w_mem_m1, w_mem_m2;
  logic w_hazard, w_stall, w_issue;
  logic [1:0] w_fwd1, w_fwd2;
  logic w_unused_ld;

  // Load flags beyond EX only travel with the entry; nothing downstream consumes them.
  assign w_unused_ld = r_mem_ld ^ r_wb_ld;

  // A source matches only when the instruction actually reads it.
  assign w_ex_m1  = id_rs1_use & r_ex_we  & (r_ex_rd  == id_rs1);
  assign w_ex_m2  = id_rs2_use & r_ex_we  & (r_ex_rd  == id_rs2);
  assign w_mem_m1 = id_rs1_use & r_mem_we & (r_mem_rd == id_rs1);
  assign w_mem_m2 = id_rs2_use & r_mem_we & (r_mem_rd == id_rs2);

`ifdef FWD_EN
  // Only a load still in EX cannot be forwarded in time.
  assign w_hazard = r_ex_ld & (w_ex_m1 | w_ex_m2);

  always_comb begin
    w_fwd1 = 2'b00;
    w_fwd2 = 2'b00;
    if (!w_stall) begin
      if (w_ex_m1)       w_fwd1 = 2'b01;
      else if (w_mem_m1) w_fwd1 = 2'b10;
      if (w_ex_m2)       w_fwd2 = 2'b01;
      else if (w_mem_m2) w_fwd2 = 2'b10;
    end
  end
`else
  assign w_hazard = w_ex_m1 | w_ex_m2 | w_mem_m1 | w_mem_m2;

  always_comb begin
    w_fwd1 = 2'b00;
    w_fwd2 = 2'b00;
  end
`endif

  assign w_stall = id_valid & ~flush & w_hazard;
  assign w_issue = id_valid & ~w_stall & ~flush;

  // Tracking pipe: EX -> MEM -> WB, advancing every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_we  <= 1'b0;
      r_ex_rd  <= 3'd0;
      r_ex_ld  <= 1'b0;
      r_mem_we <= 1'b0;
      r_mem_rd <= 3'd0;
      r_mem_ld <= 1'b0;
      r_wb_we  <= 1'b0;
      r_wb_rd  <= 3'd0;
      r_wb_ld  <= 1'b0;
    end else begin
      r_wb_we  <= r_mem_we;
      r_wb_rd  <= r_mem_rd;
      r_wb_ld  <= r_mem_ld;
      r_mem_we <= r_ex_we;
      r_mem_rd <= r_ex_rd;
      r_mem_ld <= r_ex_ld;
      if (w_issue) begin
        r_ex_we <= id_rd_we;
        r_ex_rd <= id_rd;
        r_ex_ld <= id_is_load;
      end else begin
        r_ex_we <= 1'b0;
        r_ex_rd <= 3'd0;
        r_ex_ld <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_stall_cnt <= 16'd0;
    else if (w_stall && (r_stall_cnt != 16'hFFFF))
      r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign stall     = w_stall;
  assign fwd1_sel  = w_fwd1;
  assign fwd2_sel  = w_fwd2;
  assign ex_we     = r_ex_we;
  assign ex_rd     = r_ex_rd;
  assign mem_we    = r_mem_we;
  assign mem_rd    = r_mem_rd;
  assign wb_we     = r_wb_we;
  assign wb_rd     = r_wb_rd;
  assign stall_cnt = r_stall_cnt;

endmodule
